// File: rtl/tcp_listen_entry_if.sv
// Bus bundle for one passive-open TCP connection entry: inbound segment
// notifications, transmit completions and the outbound segment request.
interface tcp_listen_entry_if #(
  parameter int unsigned SEQ_W  = 32,
  parameter int unsigned FLAG_W = 8,
  parameter int unsigned SIZE_W = 16
);
  logic              open_v_i;
  logic [SEQ_W-1:0]  init_seq_i;
  logic              close_v_i;
  logic              cancel_v_i;
  logic              rec_v_i;
  logic [SIZE_W-1:0] rec_size_i;
  logic [SEQ_W-1:0]  rec_seq_i;
  logic [SEQ_W-1:0]  rec_ack_i;
  logic [FLAG_W-1:0] rec_flag_i;
  logic              sent_v_i;
  logic [SIZE_W-1:0] send_size_i;
  logic              valid_o;
  logic              est_o;
  logic              req_v_o;
  logic [FLAG_W-1:0] req_flag_o;
  logic [SEQ_W-1:0]  req_seq_o;
  logic [SEQ_W-1:0]  req_ack_o;

  // Driver side (socket controller / environment)
  modport master (
    output open_v_i, init_seq_i, close_v_i, cancel_v_i,
    output rec_v_i, rec_size_i, rec_seq_i, rec_ack_i, rec_flag_i,
    output sent_v_i, send_size_i,
    input  valid_o, est_o, req_v_o, req_flag_o, req_seq_o, req_ack_o
  );

  // Entry side
  modport slave (
    input  open_v_i, init_seq_i, close_v_i, cancel_v_i,
    input  rec_v_i, rec_size_i, rec_seq_i, rec_ack_i, rec_flag_i,
    input  sent_v_i, send_size_i,
    output valid_o, est_o, req_v_o, req_flag_o, req_seq_o, req_ack_o
  );
endinterface

// File: rtl/tcp_listen_entry.sv
// Single TCP connection entry for a passive open: tracks the handshake,
// the established data phase (seq/ack accounting) and the passive close.
module tcp_listen_entry #(
  parameter int unsigned SEQ_W  = 32,
  parameter int unsigned FLAG_W = 8,
  parameter int unsigned SIZE_W = 16
) (
  input logic                clk,
  input logic                nreset,
  tcp_listen_entry_if.slave  bus
);

  localparam int unsigned BitAck = 3;
  localparam int unsigned BitSyn = 6;
  localparam int unsigned BitFin = 7;

  localparam logic [FLAG_W-1:0] FlagAck    = FLAG_W'(8'h08);
  localparam logic [FLAG_W-1:0] FlagSynAck = FLAG_W'(8'h48);
  localparam logic [FLAG_W-1:0] FlagFinAck = FLAG_W'(8'h88);

  typedef enum logic [8:0] {
    StIdle       = 9'b0_0000_0001,
    StListen     = 9'b0_0000_0010,
    StSynackEmit = 9'b0_0000_0100,
    StSynRcvd    = 9'b0_0000_1000,
    StEst        = 9'b0_0001_0000,
    StAckfinEmit = 9'b0_0010_0000,
    StCloseWait  = 9'b0_0100_0000,
    StFinEmit    = 9'b0_1000_0000,
    StLastAck    = 9'b1_0000_0000
  } state_e;

  state_e           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [SEQ_W-1:0] ack_q, ack_d;
  logic             ack_pend_q, ack_pend_d;

  logic rec_ack_f, rec_syn_f, rec_fin_f;
  assign rec_ack_f = bus.rec_flag_i[BitAck];
  assign rec_syn_f = bus.rec_flag_i[BitSyn];
  assign rec_fin_f = bus.rec_flag_i[BitFin];

  // State and sequence registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q    <= StIdle;
      seq_q      <= '0;
      ack_q      <= '0;
      ack_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      ack_q      <= ack_d;
      ack_pend_q <= ack_pend_d;
    end
  end

  // Next-state and seq/ack update logic; cancel overrides everything
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    ack_d      = ack_q;
    ack_pend_d = ack_pend_q;
    unique case (state_q)
      StIdle: begin
        if (bus.open_v_i) begin
          state_d = StListen;
          seq_d   = bus.init_seq_i;
          ack_d   = '0;
        end
      end
      StListen: begin
        if (bus.rec_v_i && rec_syn_f && !rec_ack_f) begin
          state_d = StSynackEmit;
          ack_d   = bus.rec_seq_i + SEQ_W'(1);
        end
      end
      StSynackEmit: begin
        if (bus.sent_v_i) begin
          state_d = StSynRcvd;
          seq_d   = seq_q + SEQ_W'(1);
        end
      end
      StSynRcvd: begin
        if (bus.rec_v_i && rec_ack_f && !rec_syn_f && (bus.rec_ack_i == seq_q)) begin
          state_d = StEst;
        end
      end
      StEst: begin
        // Transmit and receive sides are independent; a new receive wins the pending flag
        if (bus.sent_v_i) begin
          seq_d      = seq_q + SEQ_W'(bus.send_size_i);
          ack_pend_d = 1'b0;
        end
        if (bus.rec_v_i) begin
          if (rec_fin_f) begin
            state_d    = StAckfinEmit;
            ack_d      = ack_q + SEQ_W'(bus.rec_size_i) + SEQ_W'(1);
            ack_pend_d = 1'b0;
          end else begin
            ack_d = ack_q + SEQ_W'(bus.rec_size_i);
            if (bus.rec_size_i != '0) ack_pend_d = 1'b1;
          end
        end
      end
      StAckfinEmit: begin
        if (bus.sent_v_i) state_d = StCloseWait;
      end
      StCloseWait: begin
        if (bus.close_v_i) state_d = StFinEmit;
      end
      StFinEmit: begin
        if (bus.sent_v_i) begin
          state_d = StLastAck;
          seq_d   = seq_q + SEQ_W'(1);
        end
      end
      StLastAck: begin
        if (bus.rec_v_i && rec_ack_f && (bus.rec_ack_i == seq_q)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (bus.cancel_v_i) begin
      state_d    = StIdle;
      ack_pend_d = 1'b0;
    end
  end

  // Outbound request and status decode
  always_comb begin
    bus.valid_o    = (state_q != StIdle);
    bus.est_o      = (state_q == StEst);
    bus.req_seq_o  = seq_q;
    bus.req_ack_o  = ack_q;
    bus.req_v_o    = 1'b0;
    bus.req_flag_o = FlagAck;
    unique case (state_q)
      StSynackEmit: begin
        bus.req_v_o    = 1'b1;
        bus.req_flag_o = FlagSynAck;
      end
      StFinEmit: begin
        bus.req_v_o    = 1'b1;
        bus.req_flag_o = FlagFinAck;
      end
      StAckfinEmit: bus.req_v_o = 1'b1;
      StEst:        bus.req_v_o = ack_pend_q;
      default:      ;
    endcase
  end

endmodule

// File: doc/tcp_listen_entry.md
TCP_LISTEN_ENTRY -- requirements
Module: tcp_listen_entry

Interface
REQ-001 Parameter SEQ_W, 32, width of sequence and acknowledgement numbers.
REQ-002 Parameter FLAG_W, 8, TCP flag vector width; bit indices: ACK=3, SYN=6, FIN=7.
REQ-003 Parameter SIZE_W, 16, payload byte-count width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 nreset  in  1  reset, synchronous and active-low.
REQ-006 open_v_i  in  1  arm entry for a passive open; honoured only in IDLE.
REQ-007 init_seq_i  in  SEQ_W  initial send sequence number, sampled with open_v_i.
REQ-008 close_v_i  in  1  local close request; honoured only in CLOSE_WAIT.
REQ-009 cancel_v_i  in  1  abort; forces IDLE.
REQ-010 rec_v_i / rec_size_i / rec_seq_i / rec_ack_i / rec_flag_i  in  1/SIZE_W/SEQ_W/SEQ_W/FLAG_W  validated inbound TCP header for this socket.
REQ-011 sent_v_i / send_size_i  in  1/SIZE_W  requested segment transmitted, with its payload byte count.
REQ-012 valid_o  out  1  entry allocated (state != IDLE).
REQ-013 est_o  out  1  state == EST.
REQ-014 req_v_o  out  1  request to transmit a segment.
REQ-015 req_flag_o / req_seq_o / req_ack_o  out  FLAG_W/SEQ_W/SEQ_W  header for the next segment; req_seq_o=seq_q and req_ack_o=ack_q at all times.

Function
REQ-016 State register SHALL be one-hot over IDLE, LISTEN, SYNACK_EMIT, SYN_RCVD, EST, ACKFIN_EMIT, CLOSE_WAIT, FIN_EMIT, LAST_ACK.
REQ-017 IDLE->LISTEN on open_v_i; seq_q<=init_seq_i, ack_q<=0 in the same edge.
REQ-018 LISTEN->SYNACK_EMIT on rec_v_i with SYN=1 and ACK=0; ack_q<=rec_seq_i+1 (mod 2^SEQ_W). Any other segment in LISTEN SHALL be ignored.
REQ-019 SYNACK_EMIT->SYN_RCVD on sent_v_i; seq_q<=seq_q+1.
REQ-020 SYN_RCVD->EST on rec_v_i with ACK=1, SYN=0 and rec_ack_i==seq_q; mismatched segments SHALL be ignored.
REQ-021 In EST, rec_v_i without FIN SHALL add rec_size_i to ack_q and, if rec_size_i!=0, set ack_pend_q.
REQ-022 In EST, sent_v_i SHALL add send_size_i to seq_q and clear ack_pend_q.
REQ-023 EST->ACKFIN_EMIT on rec_v_i with FIN=1; ack_q<=ack_q+rec_size_i+1.
REQ-024 ACKFIN_EMIT->CLOSE_WAIT on sent_v_i (pure ACK, seq_q unchanged).
REQ-025 CLOSE_WAIT->FIN_EMIT on close_v_i; FIN_EMIT->LAST_ACK on sent_v_i with seq_q<=seq_q+1.
REQ-026 LAST_ACK->IDLE on rec_v_i with ACK=1 and rec_ack_i==seq_q.
REQ-027 req_v_o SHALL be 1 in SYNACK_EMIT, ACKFIN_EMIT, FIN_EMIT, or when ack_pend_q=1 in EST; else 0.
REQ-028 req_flag_o SHALL be 8'h48 (SYN|ACK) in SYNACK_EMIT, 8'h88 (FIN|ACK) in FIN_EMIT, 8'h08 (ACK) in all other states.
REQ-029 sent_v_i outside emit states and outside EST SHALL not change state or seq_q.
REQ-030 rec_v_i and sent_v_i in the same EST cycle SHALL update ack_q and seq_q independently; ack_pend_q SHALL end at 1 if rec_size_i!=0, else 0.
REQ-031 cancel_v_i SHALL force IDLE and clear ack_pend_q on the next edge, overriding every other input including open_v_i.
REQ-032 All adds SHALL wrap modulo 2^SEQ_W; carry discarded.

Reset
REQ-033 nreset=0 at an edge SHALL set state IDLE, seq_q=0, ack_q=0, ack_pend_q=0, giving valid_o=0, est_o=0, req_v_o=0, req_flag_o=8'h08, regardless of state.

Verification
REQ-034 open(init_seq=0x100); SYN rec_seq=0x500 -> req_v_o=1, flag 0x48, seq 0x100, ack 0x501; sent -> SYN_RCVD, seq 0x101.
REQ-035 In SYN_RCVD: ACK with rec_ack=0x100 -> stays SYN_RCVD; rec_ack=0x101 -> est_o=1, req_v_o=0.
REQ-036 EST, rec size 20 -> ack +20, req_v_o=1 flag 0x08; sent size 0 -> req_v_o=0; same-cycle rec 10 + sent 5 -> ack +10, seq +5, req_v_o=1.
REQ-037 Passive close: FIN size 0 -> flag 0x08, ack +1; sent; close_v_i -> flag 0x88; sent -> seq +1; ACK matching -> valid_o=0.
REQ-038 Wrap: init_seq=0xFFFFFFFF, SYN-ACK sent -> seq 0x00000000; SYN rec_seq=0xFFFFFFFF -> ack 0x00000000.
REQ-039 cancel_v_i in FIN_EMIT, and nreset=0 in EST -> IDLE next edge, valid_o=0, req_v_o=0.
